// File: rtl/pipe_pkg.sv
// Shared types and field layouts for the core's stage-boundary registers.
// Bit positions below describe the ID/EX control field.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  localparam int CTRL_WB_EN       = 0;
  localparam int CTRL_MEM_R       = 1;
  localparam int CTRL_MEM_W       = 2;
  localparam int CTRL_EXE_CMD_LSB = 3;
  localparam int CTRL_EXE_CMD_MSB = 6;
  localparam int CTRL_B           = 7;
  localparam int CTRL_S           = 8;

  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 9;
  localparam int IDEX_DATA_W  = 105;
  localparam int EXMEM_CTRL_W = 3;
  localparam int EXMEM_DATA_W = 68;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 68;

endpackage

// File: rtl/pipe_stage_reg.sv
// Stage register with valid/ready handshake, optional 2-entry skid and flush.
// Latency 1 cycle; with SKID_EN=1 in_ready is registered (no out_ready->in_ready path).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = IDEX_CTRL_W,
  parameter int DATA_W  = IDEX_DATA_W,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_acc;
  logic              w_rel;
  logic              w_main_ld_in;
  logic              w_main_ld_skid;
  logic              w_skid_ld;

  assign out_valid = (r_state != ST_EMPTY);
  assign out_ctrl  = out_valid ? r_main_ctrl : '0;
  assign out_data  = r_main_data;

  assign w_acc = in_valid & in_ready;
  assign w_rel = out_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt  = ST_FULL;
            w_main_ld_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_acc && w_rel) begin
            w_main_ld_in = 1'b1;
          end else if (w_rel) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_acc) begin
            // Only reachable with the skid present; without it in_ready implies release.
            w_state_nxt = ST_SKID;
            w_skid_ld   = 1'b1;
          end
        end
        ST_SKID: begin
          if (w_rel) begin
            w_state_nxt    = ST_FULL;
            w_main_ld_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == ST_EMPTY) begin
        r_main_ctrl <= '0;
      end else if (w_main_ld_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_main_ld_skid) begin
        r_main_ctrl <= w_skid_ctrl;
        r_main_data <= w_skid_data;
      end
    end
  end

  if (SKID_EN) begin : g_skid
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_rdy;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_skid_ctrl <= '0;
        r_skid_data <= '0;
        r_in_rdy    <= 1'b1;
      end else begin
        r_in_rdy <= (w_state_nxt != ST_SKID);
        if (flush || w_main_ld_skid) begin
          r_skid_ctrl <= '0;
        end else if (w_skid_ld) begin
          r_skid_ctrl <= in_ctrl;
          r_skid_data <= in_data;
        end
      end
    end

    assign w_skid_ctrl = r_skid_ctrl;
    assign w_skid_data = r_skid_data;
    assign in_ready    = ~rst & r_in_rdy;
  end else begin : g_noskid
    logic w_unused_skid_ld;
    assign w_unused_skid_ld = w_skid_ld;
    assign w_skid_ctrl      = '0;
    assign w_skid_data      = '0;
    assign in_ready         = ~rst & (~out_valid | out_ready);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid and a non-skid instance with identical stimulus; directed table,
// hand sequences and a random phase, all scored against per-instance FIFOs.
module tb_pipe_stage_reg;
  localparam int CW = 9;
  localparam int DW = 105;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } pl_t;

  typedef struct {
    logic          iv, ordy, fl;
    logic [CW-1:0] c;
    logic          e_ir, e_ov;
    logic [CW-1:0] e_oc;
    logic          chk_n;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic ir_s, ov_s, ir_n, ov_n;
  logic [CW-1:0] oc_s, oc_n;
  logic [DW-1:0] od_s, od_n;

  int n_cmp = 0;
  int n_err = 0;
  pl_t  sbq[2][$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_s),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_s), .out_ready(out_ready),
    .out_ctrl(oc_s), .out_data(od_s));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_n),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_n), .out_ready(out_ready),
    .out_ctrl(oc_n), .out_data(od_n));

  function automatic logic [DW-1:0] mk(input logic [CW-1:0] c);
    return {c, 87'h5A5A_C3C3, c};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic sb_step(input int d, input logic ov, input logic ir,
                         input logic [CW-1:0] oc, input logic [DW-1:0] od);
    pl_t e;
    if (!ov) chk($sformatf("bubble_ctrl_dut%0d", d), DW'(oc), '0);
    if (rst || flush) begin
      sbq[d].delete();
      return;
    end
    if (ov && out_ready) begin
      if (sbq[d].size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_out_dut%0d got ctrl %h expected no output", d, oc);
      end else begin
        e = sbq[d].pop_front();
        chk($sformatf("sb_payload_dut%0d", d), DW'({oc, od}), DW'({e.c, e.d}));
      end
    end
    if (in_valid && ir) sbq[d].push_back('{c: in_ctrl, d: in_data});
  endtask

  task automatic step(input logic r, input logic v, input logic o, input logic f,
                      input logic [CW-1:0] c, input logic [DW-1:0] dd);
    @(negedge clk);
    rst = r; in_valid = v; out_ready = o; flush = f; in_ctrl = c; in_data = dd;
    #1;
    sb_step(0, ov_s, ir_s, oc_s, od_s);
    sb_step(1, ov_n, ir_n, oc_n, od_n);
  endtask

  task automatic add(input logic iv, input logic ordy, input logic fl, input logic [CW-1:0] c,
                     input logic e_ir, input logic e_ov, input logic [CW-1:0] e_oc,
                     input logic chk_n);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.c = c;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_oc = e_oc; v.chk_n = chk_n;
    tbl.push_back(v);
  endtask

  initial begin
    logic [127:0] rnd;
    logic v, o, f;
    logic [CW-1:0] c;

    // Streaming 1..8 with a 1-cycle latency and no gaps.
    add(1, 1, 0, 9'h001, 1, 0, 9'h000, 1);
    for (int i = 2; i <= 8; i++) add(1, 1, 0, CW'(i), 1, 1, CW'(i - 1), 1);
    add(0, 1, 0, 9'h000, 1, 1, 9'h008, 1);
    add(0, 1, 0, 9'h000, 1, 0, 9'h000, 1);
    // Backpressure: A at output, out_ready low 3 cycles, B to skid, C held upstream.
    add(1, 1, 0, 9'h00A, 1, 0, 9'h000, 1);
    add(1, 0, 0, 9'h00B, 1, 1, 9'h00A, 1);
    add(1, 0, 0, 9'h00C, 0, 1, 9'h00A, 1);
    add(1, 0, 0, 9'h00C, 0, 1, 9'h00A, 1);
    add(1, 1, 0, 9'h00C, 0, 1, 9'h00A, 1);
    add(1, 1, 0, 9'h00C, 1, 1, 9'h00B, 0);
    add(0, 1, 0, 9'h000, 1, 1, 9'h00C, 0);
    add(0, 1, 0, 9'h000, 1, 0, 9'h000, 1);
    // Flush while in SKID with a word offered.
    add(1, 0, 0, 9'h021, 1, 0, 9'h000, 1);
    add(1, 0, 0, 9'h022, 1, 1, 9'h021, 1);
    add(1, 1, 1, 9'h001, 0, 1, 9'h021, 1);
    add(0, 1, 0, 9'h000, 1, 0, 9'h000, 1);
    // Accept and release together in FULL.
    add(1, 0, 0, 9'h031, 1, 0, 9'h000, 1);
    add(1, 1, 0, 9'h032, 1, 1, 9'h031, 1);
    add(0, 0, 0, 9'h000, 1, 1, 9'h032, 1);
    add(0, 1, 0, 9'h000, 1, 1, 9'h032, 1);
    add(0, 1, 0, 9'h000, 1, 0, 9'h000, 1);
    // Flush in EMPTY drops the offered word.
    add(1, 1, 1, 9'h040, 1, 0, 9'h000, 1);
    add(0, 1, 0, 9'h000, 1, 0, 9'h000, 1);

    rst = 1'b1; in_valid = 1'b1; in_ctrl = 9'h1FF; in_data = '1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 9'h1FF, '1);
      chk("rst_ov_s", DW'(ov_s), 0);   chk("rst_oc_s", DW'(oc_s), 0);
      chk("rst_od_s", od_s, 0);        chk("rst_ir_s", DW'(ir_s), 0);
      chk("rst_ov_n", DW'(ov_n), 0);   chk("rst_od_n", od_n, 0);
      chk("rst_ir_n", DW'(ir_n), 0);
    end
    step(0, 0, 1, 0, 0, 0);
    chk("post_rst_ir_s", DW'(ir_s), 1);
    chk("post_rst_ir_n", DW'(ir_n), 1);

    foreach (tbl[i]) begin
      step(0, tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].c, mk(tbl[i].c));
      chk($sformatf("tbl%0d_ir_s", i), DW'(ir_s), DW'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_ov_s", i), DW'(ov_s), DW'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_oc_s", i), DW'(oc_s), DW'(tbl[i].e_oc));
      if (tbl[i].chk_n) begin
        chk($sformatf("tbl%0d_ov_n", i), DW'(ov_n), DW'(tbl[i].e_ov));
        chk($sformatf("tbl%0d_oc_n", i), DW'(oc_n), DW'(tbl[i].e_oc));
      end
    end

    // Reset while in SKID: both entries lost, clean EMPTY afterwards.
    step(0, 1, 0, 0, 9'h051, mk(9'h051));
    step(0, 1, 0, 0, 9'h052, mk(9'h052));
    step(1, 1, 1, 0, 9'h053, mk(9'h053));
    chk("skidrst_ir_during", DW'(ir_s), 0);
    chk("skidrst_oc_before", DW'(oc_s), DW'(9'h051));
    step(0, 0, 1, 0, 0, 0);
    chk("skidrst_ov", DW'(ov_s), 0);
    chk("skidrst_od", od_s, 0);
    chk("skidrst_ir_after", DW'(ir_s), 1);

    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 63) == 0);
      c = CW'($urandom);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      step(0, v, o, f, c, rnd[DW-1:0]);
    end

    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, 0);
    chk("drain_empty_s", DW'(sbq[0].size()), 0);
    chk("drain_empty_n", DW'(sbq[1].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
